// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    BUSY,
    DONE
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic             ge;

  always_comb begin
    shifted = {rem_i, bit_i};
    ge      = shifted >= {2'b00, divisor_i};
    q_bit_o = ge;
    // The kept remainder is always below the divisor, so it fits in WIDTH+1 bits.
    rem_o   = (WIDTH+1)'(ge ? (shifted - {2'b00, divisor_i}) : shifted);
  end

endmodule

// File: rtl/hilo_div_engine.sv
// Multi-cycle signed/unsigned restoring divider producing {remainder, quotient} for HI/LO.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module hilo_div_engine
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t           state;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     a_orig;
  logic                 q_neg;
  logic                 r_neg;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 abort;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quo_next;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  always_comb begin
    abort    = flush | annul_i;
    a_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    b_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    quo_next = {dq[WIDTH-2:0], step_q};
    q_fix    = q_neg ? ('0 - quo_next) : quo_next;
    r_fix    = r_neg ? ('0 - step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];
  end

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem),
    .bit_i     (dq[WIDTH-1]),
    .divisor_i (dvs),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dq       <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (abort) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i) begin
            a_orig <= opdata1_i;
            dvs    <= b_mag;
            dq     <= a_mag;
            rem    <= '0;
            cnt    <= '0;
            q_neg  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg  <= signed_div_i & opdata1_i[WIDTH-1];
            if (opdata2_i == '0) begin
              state <= DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (a_mag < b_mag) begin
              state    <= DONE;
              ready_q  <= 1'b1;
              result_q <= {opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        DIVZERO: begin
          state    <= DONE;
          ready_q  <= 1'b1;
          result_q <= {a_orig, {WIDTH{1'b1}}};
        end
        BUSY: begin
          rem <= step_rem;
          dq  <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state    <= DONE;
            ready_q  <= 1'b1;
            result_q <= {r_fix, q_fix};
          end
        end
        DONE: begin
          state    <= IDLE;
          ready_q  <= 1'b0;
          result_q <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // An abort in the DONE cycle must suppress the pulse that is already registered.
  always_comb begin
    ready_o  = ready_q & ~(rst | abort);
    result_o = ready_o ? result_q : '0;
  end

endmodule
